// File: rtl/ip_to_l2_framer_if.sv
// Byte-stream bundle between the framer, its payload FIFO (FWFT) and the MAC TX sink.
interface ip_to_l2_framer_if;
    logic [7:0] in_dout;
    logic       in_empty;
    logic       in_rd;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_sop;
    logic       out_eop;
    logic       out_abort;
    logic       out_ready;

    modport master (
        input  in_dout, in_empty, out_ready,
        output in_rd, out_data, out_valid, out_sop, out_eop, out_abort
    );

    modport slave (
        output in_dout, in_empty, out_ready,
        input  in_rd, out_data, out_valid, out_sop, out_eop, out_abort
    );
endinterface

// File: rtl/ip_to_l2_framer.sv
// Wraps one IP packet from a FWFT byte FIFO into an Ethernet II frame
// (header, payload, zero pad, CRC-32 FCS) on a valid/ready byte stream.
module ip_to_l2_framer #(
    parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC     = 48'h0200_0000_0001,
    parameter logic [15:0] ETHERTYPE   = 16'h0800,
    parameter int unsigned MIN_PAYLOAD = 46,
    parameter int unsigned MAX_LEN     = 1500,
    parameter int unsigned IFG_CYCLES  = 12,
    parameter int unsigned UNDERRUN_TO = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pkt_start_i,
    input  logic [10:0]       pkt_len_i,
    output logic              busy_o,
    output logic              len_err_o,
    output logic              underrun_err_o,
    ip_to_l2_framer_if.master bus
);
    localparam logic [111:0] HDR      = {DST_MAC, SRC_MAC, ETHERTYPE};
    localparam logic [31:0]  CRC_POLY = 32'hEDB8_8320;
    localparam logic [10:0]  MIN_L    = 11'(MIN_PAYLOAD);
    localparam logic [10:0]  MAX_L    = 11'(MAX_LEN);
    localparam logic [10:0]  IFG_LAST = 11'(IFG_CYCLES - 1);
    localparam logic [10:0]  TO_LAST  = 11'(UNDERRUN_TO - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PAY,
        S_PAD,
        S_FCS,
        S_IFG
    } state_t;

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'h0, b};
        for (int unsigned i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    state_t      state_q;
    logic [10:0] cnt_q;
    logic [10:0] len_q;
    logic [10:0] wait_q;
    logic [31:0] crc_q;
    logic [31:0] crc_d;
    logic [7:0]  out_data_q;
    logic        out_valid_q;
    logic        out_sop_q;
    logic        out_eop_q;
    logic        out_abort_q;
    logic        fcs_out_q;
    logic        busy_q;
    logic        len_err_q;
    logic        underrun_q;

    logic         xfer;
    logic         can_load;
    logic         pop;
    logic         starve_to;
    logic [111:0] hdr_sh;
    logic [31:0]  fcs_sh;

    // CRC advances on the byte leaving the output register; FCS bytes are excluded
    // so the complemented value stays frozen while it is being shifted out.
    always_comb begin
        xfer      = out_valid_q && bus.out_ready;
        can_load  = !out_valid_q || bus.out_ready;
        crc_d     = (xfer && !fcs_out_q) ? crc_byte(crc_q, out_data_q) : crc_q;
        pop       = rst_n && (state_q == S_PAY) && can_load && !bus.in_empty;
        starve_to = (state_q == S_PAY) && !out_valid_q && bus.in_empty && (wait_q == TO_LAST);
        hdr_sh    = HDR << {cnt_q[3:0], 3'b000};
        fcs_sh    = ~crc_d >> {cnt_q[1:0], 3'b000};
    end

    assign bus.in_rd       = pop;
    assign bus.out_data    = out_data_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_sop     = out_sop_q;
    assign bus.out_eop     = out_eop_q;
    assign bus.out_abort   = out_abort_q;
    assign busy_o          = busy_q;
    assign len_err_o       = len_err_q;
    assign underrun_err_o  = underrun_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            wait_q      <= '0;
            crc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_abort_q <= 1'b0;
            fcs_out_q   <= 1'b0;
            busy_q      <= 1'b0;
            len_err_q   <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            len_err_q  <= 1'b0;
            underrun_q <= 1'b0;
            crc_q      <= crc_d;

            case (state_q)
                S_IDLE: begin
                    crc_q <= '1;
                    if (pkt_start_i) begin
                        if (pkt_len_i == '0 || pkt_len_i > MAX_L) begin
                            len_err_q <= 1'b1;
                        end else begin
                            len_q       <= pkt_len_i;
                            busy_q      <= 1'b1;
                            out_data_q  <= HDR[111:104];
                            out_valid_q <= 1'b1;
                            out_sop_q   <= 1'b1;
                            out_eop_q   <= 1'b0;
                            out_abort_q <= 1'b0;
                            fcs_out_q   <= 1'b0;
                            cnt_q       <= 11'd1;
                            wait_q      <= '0;
                            state_q     <= S_HDR;
                        end
                    end
                end

                S_HDR: begin
                    if (can_load) begin
                        out_data_q  <= hdr_sh[111:104];
                        out_valid_q <= 1'b1;
                        out_sop_q   <= 1'b0;
                        if (cnt_q == 11'd13) begin
                            cnt_q   <= '0;
                            state_q <= S_PAY;
                        end else begin
                            cnt_q <= cnt_q + 11'd1;
                        end
                    end
                end

                S_PAY: begin
                    if (pop) begin
                        out_data_q  <= bus.in_dout;
                        out_valid_q <= 1'b1;
                        out_sop_q   <= 1'b0;
                        wait_q      <= '0;
                        if (cnt_q == len_q - 11'd1) begin
                            if (len_q < MIN_L) begin
                                cnt_q   <= cnt_q + 11'd1;
                                state_q <= S_PAD;
                            end else begin
                                cnt_q   <= '0;
                                state_q <= S_FCS;
                            end
                        end else begin
                            cnt_q <= cnt_q + 11'd1;
                        end
                    end else if (starve_to) begin
                        out_data_q  <= '0;
                        out_valid_q <= 1'b1;
                        out_eop_q   <= 1'b1;
                        out_abort_q <= 1'b1;
                        underrun_q  <= 1'b1;
                        wait_q      <= '0;
                        cnt_q       <= '0;
                        state_q     <= S_IFG;
                    end else if (can_load) begin
                        // Only cycles with an empty output register count as starvation.
                        out_valid_q <= 1'b0;
                        if (!out_valid_q) begin
                            wait_q <= wait_q + 11'd1;
                        end
                    end
                end

                S_PAD: begin
                    if (can_load) begin
                        out_data_q  <= '0;
                        out_valid_q <= 1'b1;
                        if (cnt_q == MIN_L - 11'd1) begin
                            cnt_q   <= '0;
                            state_q <= S_FCS;
                        end else begin
                            cnt_q <= cnt_q + 11'd1;
                        end
                    end
                end

                S_FCS: begin
                    if (can_load) begin
                        out_data_q  <= fcs_sh[7:0];
                        out_valid_q <= 1'b1;
                        fcs_out_q   <= 1'b1;
                        if (cnt_q == 11'd3) begin
                            out_eop_q <= 1'b1;
                            cnt_q     <= '0;
                            state_q   <= S_IFG;
                        end else begin
                            cnt_q <= cnt_q + 11'd1;
                        end
                    end
                end

                S_IFG: begin
                    if (out_valid_q) begin
                        if (bus.out_ready) begin
                            out_valid_q <= 1'b0;
                            out_data_q  <= '0;
                            out_sop_q   <= 1'b0;
                            out_eop_q   <= 1'b0;
                            out_abort_q <= 1'b0;
                            fcs_out_q   <= 1'b0;
                        end
                    end else if (cnt_q == IFG_LAST) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 11'd1;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ip_to_l2_framer.sv
// Random-stimulus bench: a FIFO/sink model drives the framer and every transferred
// byte is compared against a frame image built from the Ethernet II rules.
module tb_ip_to_l2_framer;
    localparam logic [47:0] DST         = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] SRC         = 48'h0200_0000_0001;
    localparam logic [15:0] ETYPE       = 16'h0800;
    localparam int unsigned MIN_PAYLOAD = 46;
    localparam int unsigned IFG_CYCLES  = 12;
    localparam int unsigned UNDERRUN_TO = 255;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pkt_start = 1'b0;
    logic [10:0] pkt_len = '0;
    logic        busy;
    logic        len_err;
    logic        underrun_err;

    ip_to_l2_framer_if bus ();

    ip_to_l2_framer #(
        .DST_MAC    (DST),
        .SRC_MAC    (SRC),
        .ETHERTYPE  (ETYPE),
        .MIN_PAYLOAD(MIN_PAYLOAD),
        .MAX_LEN    (1500),
        .IFG_CYCLES (IFG_CYCLES),
        .UNDERRUN_TO(UNDERRUN_TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pkt_start_i   (pkt_start),
        .pkt_len_i     (pkt_len),
        .busy_o        (busy),
        .len_err_o     (len_err),
        .underrun_err_o(underrun_err),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // ---------------- FIFO and sink models ----------------
    logic [7:0] fifo_q[$];
    bit         rand_ready = 1'b0;

    initial begin
        bus.in_empty  = 1'b1;
        bus.in_dout   = 8'h00;
        bus.out_ready = 1'b1;
    end

    always @(posedge clk) begin
        #1;
        bus.in_empty  = (fifo_q.size() == 0);
        bus.in_dout   = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
        bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // ---------------- reference frame model ----------------
    logic [7:0]  exp_frame [0:2047];
    int unsigned exp_len = 0;
    int unsigned exp_idx = 0;
    int unsigned exp_pops = 0;
    bit          exp_abort = 1'b0;
    int unsigned extra = 0;
    int unsigned pops = 0;
    int unsigned gap = 0;
    int unsigned und_cnt = 0;
    int unsigned ifg_cnt = 0;
    bit          ifg_active = 1'b0;
    bit          prev_stall = 1'b0;
    logic [11:0] prev_out = '0;

    function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ b[i];
            c  = {1'b0, c[31:1]} ^ (fb ? 32'hEDB8_8320 : 32'h0);
        end
        return c;
    endfunction

    task automatic build_frame(input int unsigned len);
        logic [111:0] hdr;
        logic [31:0]  crc;
        int unsigned  avail;
        int unsigned  body;
        int unsigned  n;
        hdr   = {DST, SRC, ETYPE};
        avail = (fifo_q.size() < len) ? fifo_q.size() : len;
        n     = 0;
        for (int i = 0; i < 14; i++) begin
            exp_frame[n] = hdr[111 - 8*i -: 8];
            n = n + 1;
        end
        for (int unsigned i = 0; i < avail; i++) begin
            exp_frame[n] = fifo_q[i];
            n = n + 1;
        end
        if (avail < len) begin
            exp_frame[n] = 8'h00;
            n = n + 1;
            exp_abort = 1'b1;
            exp_pops  = avail;
        end else begin
            body = (len < MIN_PAYLOAD) ? MIN_PAYLOAD : len;
            for (int unsigned i = len; i < body; i++) begin
                exp_frame[n] = 8'h00;
                n = n + 1;
            end
            crc = 32'hFFFF_FFFF;
            for (int unsigned i = 0; i < n; i++) crc = crc_step(crc, exp_frame[i]);
            crc = ~crc;
            for (int k = 0; k < 4; k++) begin
                exp_frame[n] = crc[8*k +: 8];
                n = n + 1;
            end
            exp_abort = 1'b0;
            exp_pops  = len;
        end
        exp_len = n;
        exp_idx = 0;
        extra   = 0;
        pops    = 0;
        gap     = 0;
        und_cnt = 0;
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
            ifg_active = 1'b0;
            gap        = 0;
        end else begin
            if (prev_stall)
                chk("stall_hold", 32'({bus.out_valid, bus.out_sop, bus.out_eop, bus.out_abort, bus.out_data}),
                    32'(prev_out));
            if (bus.in_rd) begin
                chk("rd_only_when_nonempty", 32'(bus.in_empty), 32'd0);
                pops++;
                if (fifo_q.size() != 0) void'(fifo_q.pop_front());
            end
            if (underrun_err) und_cnt++;
            if (bus.out_valid) chk("busy_while_valid", 32'(busy), 32'd1);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_idx < exp_len) begin
                    chk($sformatf("byte[%0d]", exp_idx), 32'(bus.out_data), 32'(exp_frame[exp_idx]));
                    chk("sop", 32'(bus.out_sop), 32'(exp_idx == 0));
                    chk("eop", 32'(bus.out_eop), 32'(exp_idx == exp_len - 1));
                    chk("abort", 32'(bus.out_abort), 32'(exp_abort && (exp_idx == exp_len - 1)));
                    if (exp_abort && (exp_idx == exp_len - 1)) begin
                        chk("underrun_gap", gap, UNDERRUN_TO);
                        chk("underrun_pulse", 32'(underrun_err), 32'd1);
                    end
                end else begin
                    extra++;
                end
                if (bus.out_eop) begin
                    ifg_active = 1'b1;
                    ifg_cnt    = 0;
                end
                exp_idx++;
                gap = 0;
            end else if (!bus.out_valid) begin
                gap++;
                if (ifg_active) begin
                    if (busy) ifg_cnt++;
                    else begin
                        chk("ifg_length", ifg_cnt, IFG_CYCLES);
                        ifg_active = 1'b0;
                    end
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_out   = {bus.out_valid, bus.out_sop, bus.out_eop, bus.out_abort, bus.out_data};
        end
    end

    // ---------------- sequence helpers ----------------
    task automatic start_frame(input int unsigned len);
        @(posedge clk); #2;
        pkt_start = 1'b1;
        pkt_len   = 11'(len);
        @(posedge clk); #2;
        pkt_start = 1'b0;
        @(negedge clk);
        chk("first_byte_latency", 32'({bus.out_valid, bus.out_sop, bus.out_data}),
            32'({1'b1, 1'b1, DST[47:40]}));
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic wait_frame(input int unsigned budget, input string tag);
        int unsigned n;
        n = 0;
        while ((exp_idx < exp_len || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_bytes"}, exp_idx, exp_len);
        chk({tag, "_pops"}, pops, exp_pops);
        chk({tag, "_extra"}, extra, 32'd0);
        chk({tag, "_busy_low"}, 32'(busy), 32'd0);
    endtask

    task automatic fill_random(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) fifo_q.push_back(8'($urandom));
    endtask

    function automatic logic [15:0] all_outs();
        return {busy, len_err, underrun_err, bus.in_rd, bus.out_valid, bus.out_sop,
                bus.out_eop, bus.out_abort, bus.out_data};
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        logic [31:0] crc;
        int unsigned n;

        crc = 32'hFFFF_FFFF;
        for (int unsigned i = 0; i < 9; i++) crc = crc_step(crc, 8'(8'h31 + i));
        chk("model_crc_ref", ~crc, 32'hCBF4_3926);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 32'(all_outs()), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // 1: short packet, padded to minimum size
        for (int unsigned i = 0; i < 20; i++) fifo_q.push_back(8'(i));
        build_frame(20);
        chk("model_len_min", exp_len, 32'd64);
        chk("model_ethertype_hi", 32'(exp_frame[12]), 32'h08);
        chk("model_first_pad", 32'(exp_frame[34]), 32'h00);
        start_frame(20);
        wait_frame(400, "t1");

        // 2: maximum packet with random sink back-pressure
        fill_random(1500);
        build_frame(1500);
        chk("model_len_max", exp_len, 32'd1518);
        rand_ready = 1'b1;
        start_frame(1500);
        wait_frame(10000, "t2");
        rand_ready = 1'b0;

        // 3: illegal lengths
        fill_random(5);
        pops = 0;
        extra = 0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #2;
            pkt_start = 1'b1;
            pkt_len   = (k == 0) ? 11'd0 : 11'd1501;
            @(posedge clk); #2;
            pkt_start = 1'b0;
            @(negedge clk);
            chk("len_err_pulse", 32'(len_err), 32'd1);
            chk("len_err_quiet", 32'({bus.out_valid, busy, bus.in_rd}), 32'd0);
            @(negedge clk);
            chk("len_err_one_cycle", 32'(len_err), 32'd0);
        end
        repeat (4) @(negedge clk);
        chk("t3_pops", pops, 32'd0);
        chk("t3_fifo_left", fifo_q.size(), 32'd5);
        chk("t3_extra", extra, 32'd0);
        @(posedge clk); #2;
        fifo_q.delete();
        repeat (2) @(posedge clk);

        // 4: payload starvation
        fill_random(10);
        build_frame(60);
        chk("model_abort_len", exp_len, 32'd25);
        start_frame(60);
        wait_frame(800, "t4");
        chk("t4_underrun_count", und_cnt, 32'd1);

        // 5: start request during IFG is ignored
        fill_random(60);
        build_frame(30);
        start_frame(30);
        n = 0;
        while (!ifg_active && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("t5_reached_ifg", 32'(ifg_active), 32'd1);
        @(posedge clk); #2;
        pkt_start = 1'b1;
        pkt_len   = 11'd30;
        @(posedge clk); #2;
        pkt_start = 1'b0;
        wait_frame(400, "t5");
        repeat (100) @(negedge clk);
        chk("t5_no_second_frame", extra, 32'd0);
        chk("t5_pops_total", pops, 32'd30);
        chk("t5_fifo_left", fifo_q.size(), 32'd30);
        @(posedge clk); #2;
        fifo_q.delete();
        repeat (2) @(posedge clk);

        // 6: reset during payload, then a fresh frame
        fill_random(40);
        build_frame(40);
        start_frame(40);
        n = 0;
        while (exp_idx < 19 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t6_reached_pay5", exp_idx, 32'd19);
        @(posedge clk); #2;
        rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        fifo_q.delete();
        exp_len = exp_idx;
        extra   = 0;
        @(negedge clk);
        chk("t6_outputs_after_reset", 32'(all_outs()), 32'd0);
        repeat (20) @(negedge clk);
        chk("t6_no_eop_after_reset", extra, 32'd0);
        fill_random(25);
        build_frame(25);
        start_frame(25);
        wait_frame(400, "t6");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end
endmodule
